fadsu_nibble_seq: RTL
=====================

Name: fadsu_nibble_seq

Overview:
- Multi-cycle add/subtract sequencer that time-shares one 4-bit add/sub slice across a WIDTH-bit operand pair, one nibble per clock, LSB nibble first.
- Slice semantics: B is passed through when CON=1 and inverted when CON=0; BCI is carry-in.
- Carry is chained between nibbles through a carry register.
- Sits beside the slice library cells as the area-saving alternative to a full-width ripple adder in control and datapath logic.

Parameters:
- WIDTH, 16, operand/result width in bits; multiple of 4, minimum 4. NIB = WIDTH/4 nibble steps.

Ports:
- CK  input  1  rising-edge clock
- RSTN  input  1  synchronous active-low reset
- START  input  1  request; sampled only when BUSY=0
- CON  input  1  1 = add (A+B+BCI), 0 = subtract (A+~B+BCI); captured on accepted START
- BCI  input  1  carry-in; 1 for true two's-complement subtract; captured on accepted START
- A  input  WIDTH  operand A; captured on accepted START
- B  input  WIDTH  operand B; captured on accepted START
- BUSY  output  1  high while nibbles are being processed
- DONE  output  1  one-cycle pulse; S, BCO, OVF are valid from this cycle
- S  output  WIDTH  result, (A + (CON?B:~B) + BCI) mod 2^WIDTH
- BCO  output  1  carry out of bit WIDTH-1
- OVF  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Clock and reset: one clock CK. Reset is synchronous and active-low on RSTN.
- Reset (RSTN=0 at a CK edge):
  - state returns to IDLE;
  - BUSY, DONE, S, BCO, OVF, the nibble counter and the carry register all go to 0.
  - Reset mid-operation aborts the operation with no DONE pulse. Partial results are discarded.
- States: IDLE, RUN, FIN.
- IDLE:
  - BUSY=0, DONE=0.
  - START=1 captures A, B, CON, loads carry register with BCI, sets counter=0, and moves to RUN.
- RUN:
  - BUSY=1.
  - Each cycle computes nibble k = counter: sum4 = A[4k+3:4k] + (CON ? B : ~B)[4k+3:4k] + carry.
  - sum4[3:0] is written into the internal result register at nibble k; the carry register takes the nibble carry-out.
  - On k = NIB-1: also record the carry into bit 3 of that nibble (for OVF), then go to FIN. Otherwise counter increments.
  - START is ignored in RUN. Operand inputs may change freely during RUN.
- FIN:
  - Lasts exactly one cycle. DONE=1, BUSY=0.
  - S, BCO and OVF are loaded from the internal result and flags on the edge entering FIN.
  - START=1 in FIN is accepted and goes straight to RUN (back-to-back); otherwise go to IDLE.
- Latency: START accepted at edge t → RUN for NIB cycles → DONE high in cycle t+NIB+1. For WIDTH=16, DONE is high 5 cycles after the START cycle.
- Throughput: one operation per NIB+1 cycles.
- Output hold: S, BCO and OVF change only on entry to FIN or on reset. They hold their values through the following IDLE and RUN cycles.
- Carry chain: a full-width ripple (e.g. 0xFFFF+1) must propagate correctly across all nibble boundaries via the carry register.
- Boundary cases:
  - WIDTH=4 gives a single RUN cycle.
  - The counter never exceeds NIB-1.
  - No combinational path from any input to any output.

Test Plan:
- WIDTH=16, A=0x1234, B=0x0FCD, CON=1, BCI=0, START one cycle -> BUSY high 4 cycles, DONE pulse 5 cycles after START, S=0x2201, BCO=0, OVF=0.
- A=0x1000, B=0x0001, CON=0, BCI=1 -> S=0x0FFF, BCO=1; then A=0x0000, B=0x0001, CON=0, BCI=1 -> S=0xFFFF, BCO=0, OVF=0.
- A=0x7FFF, B=0x0001, CON=1, BCI=0 -> S=0x8000, BCO=0, OVF=1; A=0xFFFF, B=0x0001 add -> S=0x0000, BCO=1, OVF=0 (full ripple).
- START pulsed with different operands during RUN -> ignored, result matches first operands; START held high in the FIN cycle -> new op starts, second DONE exactly 5 cycles after the first.
- RSTN=0 for one edge during the 2nd RUN cycle -> BUSY, S, BCO, OVF = 0, no DONE; a subsequent op (0x00FF+0x0001 add) -> S=0x0100.
- WIDTH=4 instance: A=0x9, B=0x9, CON=1, BCI=0 -> DONE 2 cycles after START, S=0x2, BCO=1, OVF=1.

Source files
------------

// File: rtl/fadsu_nibble_seq.sv
// fadsu_nibble_seq
//   Multi-cycle add/subtract sequencer. One 4-bit add/sub slice is time-shared
//   across a WIDTH-bit operand pair, one nibble per clock, LSB nibble first.
//   The carry between nibbles is chained through a carry register.
//   Result: S = (A + (CON ? B : ~B) + BCI) mod 2^WIDTH.
//
// Ports
//   CK     in   rising-edge clock
//   RSTN   in   synchronous active-low reset
//   START  in   request; accepted in IDLE or FIN (ignored while BUSY)
//   CON    in   1 = add, 0 = subtract (B inverted); captured on accepted START
//   BCI    in   carry-in; captured on accepted START
//   A, B   in   WIDTH-bit operands; captured on accepted START
//   BUSY   out  high during the NIB nibble cycles
//   DONE   out  one-cycle pulse; S/BCO/OVF valid from this cycle
//   S      out  WIDTH-bit result, held until the next completion or reset
//   BCO    out  carry out of bit WIDTH-1
//   OVF    out  signed overflow (carry into MSB xor carry out of MSB)
//
// All outputs are registered or decoded from registered state only.

module fadsu_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             START,
  input  logic             CON,
  input  logic             BCI,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             BCO,
  output logic             OVF
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q,     a_d;
  // B is stored already conditioned by CON, so the slice is a plain adder.
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic [WIDTH-1:0] s_q,     s_d;
  logic             bco_q,   bco_d;
  logic             ovf_q,   ovf_d;

  int unsigned idx;
  logic [3:0]  nib_a, nib_b;
  logic [4:0]  sum5;
  logic [3:0]  low3;

  // Shared 4-bit slice operating on nibble cnt_q.
  always_comb begin
    idx   = {{(32-CW){1'b0}}, cnt_q};
    nib_a = a_q[4*idx +: 4];
    nib_b = b_q[4*idx +: 4];
    sum5  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, carry_q};
    // Bit 3 of the low 3-bit sum is the carry into the nibble MSB.
    low3  = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b0, carry_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    bco_d   = bco_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (START) begin
          a_d     = A;
          b_d     = CON ? B : ~B;
          carry_d = BCI;
          cnt_d   = '0;
          res_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        res_d[4*idx +: 4] = sum5[3:0];
        carry_d           = sum5[4];
        if (cnt_q == LAST) begin
          // Outputs are loaded straight from the merged result so they
          // appear together with DONE in the FIN cycle.
          s_d     = res_d;
          bco_d   = sum5[4];
          ovf_d   = sum5[4] ^ low3[3];
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      bco_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      bco_q   <= bco_d;
      ovf_q   <= ovf_d;
    end
  end

  assign BUSY = (state_q == ST_RUN);
  assign DONE = (state_q == ST_FIN);
  assign S    = s_q;
  assign BCO  = bco_q;
  assign OVF  = ovf_q;

endmodule
